// File: rtl/disp_pkg.sv
// disp_pkg: display-wide defaults for dot positions and counter width helpers
package disp_pkg;
  localparam int DEF_N_FIELDS = 3;
  localparam int DEF_N_DIGITS = 12;
  localparam int DEF_FIELD_OFFSET = 3;
  localparam int DEF_FIELD_STRIDE = 3;
  function automatic int clog2_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int dot_idx(input int offset, input int stride, input int k);
    return offset + (k - 1) * stride;
  endfunction
endpackage

// File: rtl/tick_div.sv
// tick_div: modulo-N counter with synchronous clear and a wrap pulse on the last count
module tick_div
  import disp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap
);
  localparam int W = clog2_w(N);
  logic [W-1:0] cnt;
  assign wrap = cnt == W'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr | wrap) ? '0 : cnt + W'(1);
endmodule

// File: rtl/dot_blink_ctrl.sv
// dot_blink_ctrl: adjust-field selection with blinking decimal point and idle timeout
module dot_blink_ctrl
  import disp_pkg::*;
#(
  parameter int N_FIELDS = DEF_N_FIELDS,
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int FIELD_OFFSET = DEF_FIELD_OFFSET,
  parameter int FIELD_STRIDE = DEF_FIELD_STRIDE,
  parameter int BLINK_HALF = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int SEL_W = $clog2(N_FIELDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_mode,
  input  logic                btn_adj,
  input  logic                blink_en,
  output logic [SEL_W-1:0]    sel,
  output logic                adj_active,
  output logic [N_DIGITS-1:0] dc_led
);
  if (dot_idx(FIELD_OFFSET, FIELD_STRIDE, N_FIELDS) >= N_DIGITS) begin : g_bad_dot
    $error("dot_blink_ctrl: highest field dot index exceeds N_DIGITS-1");
  end
  logic [SEL_W-1:0] sel_next;
  logic [N_DIGITS-1:0] led_next;
  logic phase, phase_next, sel_chg, to_clr, to_wrap, expire, blink_wrap, dot_on;
  assign to_clr = btn_mode | btn_adj | (sel == '0);
  assign expire = to_wrap & ~to_clr;
  assign adj_active = sel != '0;
  tick_div #(.N(TIMEOUT_CYC)) u_timeout (.clk(clk), .rst(rst), .clr(to_clr), .wrap(to_wrap));
  tick_div #(.N(BLINK_HALF)) u_blink (.clk(clk), .rst(rst), .clr(sel_chg), .wrap(blink_wrap));
  // a mode press outranks a coinciding expiry
  always_comb begin
    sel_next = btn_mode ? ((sel == SEL_W'(N_FIELDS)) ? '0 : sel + SEL_W'(1)) : expire ? '0 : sel;
    sel_chg = sel_next != sel;
    phase_next = sel_chg | (phase ^ blink_wrap);
    dot_on = phase_next | ~blink_en;
    led_next = '0;
    for (int k = 1; k <= N_FIELDS; k++)
      if (sel_next == SEL_W'(k)) led_next[dot_idx(FIELD_OFFSET, FIELD_STRIDE, k)] = dot_on;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel <= '0;
      phase <= 1'b1;
      dc_led <= '0;
    end else begin
      sel <= sel_next;
      phase <= phase_next;
      dc_led <= led_next;
    end
endmodule
